// File: rtl/cam_cmd_shell_if.sv
// Byte-pipe handshakes and CAM control lines shared by cam_cmd_shell and its neighbours.
// The master modport is the shell side; the slave modport is the usb_uart/cam side.
interface cam_cmd_shell_if #(
  parameter int NUM_BITS  = 32,
  parameter int NUM_CELLS = 100
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [NUM_BITS-1:0]  cam_comparand;
  logic [NUM_BITS-1:0]  cam_mask;
  logic                 cam_search;
  logic                 cam_select_first;
  logic [NUM_CELLS-1:0] cam_tags;
  logic [NUM_BITS-1:0]  cam_read;

  modport master (
    input  rx_data, rx_valid, tx_ready, cam_tags, cam_read,
    output rx_ready, tx_data, tx_valid, cam_comparand, cam_mask, cam_search, cam_select_first
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, cam_tags, cam_read,
    input  rx_ready, tx_data, tx_valid, cam_comparand, cam_mask, cam_search, cam_select_first
  );
endinterface

// File: rtl/cam_cmd_shell.sv
// ASCII command shell for a CAM: parses CR-terminated opcode+hex lines from the host
// byte pipe, drives comparand/mask/strobes and streams back fixed-width hex replies.
module cam_cmd_shell #(
  parameter int NUM_BITS   = 32,
  parameter int NUM_CELLS  = 100,
  parameter int MAX_LINE   = 32,
  parameter int SEARCH_LAT = 2
) (
  input  logic            clk_48mhz,
  input  logic            reset,
  cam_cmd_shell_if.master bus
);
  localparam int ND   = (NUM_BITS + 3) / 4;
  localparam int CW   = $clog2(NUM_CELLS + 1);
  localparam int NC   = (CW + 3) / 4;
  localparam int DMAX = (ND > NC) ? ((ND > 3) ? ND : 3) : ((NC > 3) ? NC : 3);
  localparam int RLEN = DMAX + 2;
  localparam int HW   = DMAX * 4;
  localparam int LW   = $clog2(RLEN + 1);
  localparam int CNTW = $clog2(MAX_LINE + 1);
  localparam int WW   = (SEARCH_LAT > 0) ? $clog2(SEARCH_LAT + 1) : 1;

  typedef enum logic [1:0] {ST_RX, ST_EXEC, ST_WAIT, ST_TX} state_t;
  typedef logic [RLEN-1:0][7:0] rbuf_t;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

  // Reply buffer: nd uppercase digits, most significant first, then CR LF.
  function automatic rbuf_t hex_reply(input logic [HW-1:0] v, input int nd);
    rbuf_t b;
    logic [HW-1:0] t;
    b = '0;
    for (int i = 0; i < RLEN; i++) begin
      t = v >> ((nd - 1 - i) * 4);
      if (i < nd)          b[i] = hex_char(t[3:0]);
      else if (i == nd)    b[i] = 8'h0D;
      else if (i == nd + 1) b[i] = 8'h0A;
      else                 b[i] = 8'h00;
    end
    return b;
  endfunction

  // Reply buffer from up to three left-justified ASCII characters, then CR LF.
  function automatic rbuf_t text_reply(input logic [23:0] w, input int n);
    rbuf_t b;
    logic [23:0] t;
    b = '0;
    for (int i = 0; i < RLEN; i++) begin
      t = w << (i * 8);
      if (i < n && i < 3)  b[i] = t[23:16];
      else if (i == n)     b[i] = 8'h0D;
      else if (i == n + 1) b[i] = 8'h0A;
      else                 b[i] = 8'h00;
    end
    return b;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [NUM_CELLS-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < NUM_CELLS; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  state_t              state_r;
  logic                rx_ready_r;
  logic                tx_valid_r;
  logic [7:0]          tx_data_r;
  logic [NUM_BITS-1:0] comparand_r;
  logic [NUM_BITS-1:0] mask_r;
  logic                search_r;
  logic                select_r;
  logic [NUM_BITS-1:0] acc_r;
  logic                err_r;
  logic                has_op_r;
  logic [7:0]          opcode_r;
  logic [CNTW-1:0]     cnt_r;
  rbuf_t               reply_r;
  logic [LW-1:0]       reply_len_r;
  logic [LW-1:0]       idx_r;
  logic [WW-1:0]       wait_r;

  logic                rx_fire_s;
  logic                is_hex_s;
  logic [3:0]          digit_s;

  assign rx_fire_s = rx_ready_r & bus.rx_valid;

  // Decode the incoming byte as a hex digit (either letter case).
  always_comb begin
    digit_s  = 4'h0;
    is_hex_s = 1'b0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      digit_s  = bus.rx_data[3:0];
      is_hex_s = 1'b1;
    end else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66)) begin
      digit_s  = bus.rx_data[3:0] + 4'h9;
      is_hex_s = 1'b1;
    end else begin
      digit_s  = 4'h0;
      is_hex_s = 1'b0;
    end
  end

  // Command FSM: line capture, execution, search wait and reply streaming.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_r     <= ST_RX;
      rx_ready_r  <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_data_r   <= 8'h00;
      comparand_r <= '0;
      mask_r      <= '1;
      search_r    <= 1'b0;
      select_r    <= 1'b0;
      acc_r       <= '0;
      err_r       <= 1'b0;
      has_op_r    <= 1'b0;
      opcode_r    <= 8'h00;
      cnt_r       <= '0;
      reply_r     <= '0;
      reply_len_r <= '0;
      idx_r       <= '0;
      wait_r      <= '0;
    end else begin
      search_r <= 1'b0;
      select_r <= 1'b0;
      case (state_r)
        ST_RX: begin
          rx_ready_r <= 1'b1;
          if (rx_fire_s) begin
            if (bus.rx_data == 8'h0A) begin
              err_r <= err_r;
            end else if (bus.rx_data == 8'h0D) begin
              if (cnt_r != '0 || err_r) begin
                state_r    <= ST_EXEC;
                rx_ready_r <= 1'b0;
              end
            end else if (cnt_r == CNTW'(MAX_LINE)) begin
              err_r <= 1'b1;
            end else begin
              cnt_r <= cnt_r + CNTW'(1);
              if (cnt_r == '0) begin
                opcode_r <= bus.rx_data;
              end else begin
                has_op_r <= 1'b1;
                if (is_hex_s) acc_r <= NUM_BITS'({acc_r, digit_s});
                else          err_r <= 1'b1;
              end
            end
          end
        end
        ST_EXEC: begin
          // ERR is the fallback; the opcode decode below overrides it when legal.
          state_r     <= ST_TX;
          idx_r       <= '0;
          reply_r     <= text_reply(24'h455252, 3);
          reply_len_r <= LW'(5);
          if (!err_r) begin
            case (opcode_r)
              8'h43: if (has_op_r) begin
                comparand_r <= acc_r;
                reply_r     <= text_reply(24'h4F4B00, 2);
                reply_len_r <= LW'(4);
              end
              8'h4D: if (has_op_r) begin
                mask_r      <= acc_r;
                reply_r     <= text_reply(24'h4F4B00, 2);
                reply_len_r <= LW'(4);
              end
              8'h63: if (!has_op_r) begin
                reply_r     <= hex_reply(HW'(comparand_r), ND);
                reply_len_r <= LW'(ND + 2);
              end
              8'h6D: if (!has_op_r) begin
                reply_r     <= hex_reply(HW'(mask_r), ND);
                reply_len_r <= LW'(ND + 2);
              end
              8'h52: if (!has_op_r) begin
                reply_r     <= hex_reply(HW'(bus.cam_read), ND);
                reply_len_r <= LW'(ND + 2);
              end
              8'h46: if (!has_op_r) begin
                select_r    <= 1'b1;
                reply_r     <= text_reply(24'h4F4B00, 2);
                reply_len_r <= LW'(4);
              end
              8'h53: if (!has_op_r) begin
                search_r <= 1'b1;
                wait_r   <= '0;
                state_r  <= ST_WAIT;
              end
              default: reply_len_r <= LW'(5);
            endcase
          end
        end
        ST_WAIT: begin
          if (wait_r == WW'(SEARCH_LAT)) begin
            reply_r     <= hex_reply(HW'(popcount(bus.cam_tags)), NC);
            reply_len_r <= LW'(NC + 2);
            state_r     <= ST_TX;
          end else begin
            wait_r <= wait_r + WW'(1);
          end
        end
        ST_TX: begin
          if (!tx_valid_r) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= reply_r[idx_r];
            idx_r      <= idx_r + LW'(1);
          end else if (bus.tx_ready) begin
            if (idx_r == reply_len_r) begin
              tx_valid_r <= 1'b0;
              rx_ready_r <= 1'b1;
              state_r    <= ST_RX;
              acc_r      <= '0;
              err_r      <= 1'b0;
              has_op_r   <= 1'b0;
              cnt_r      <= '0;
            end else begin
              tx_data_r <= reply_r[idx_r];
              idx_r     <= idx_r + LW'(1);
            end
          end
        end
        default: state_r <= ST_RX;
      endcase
    end
  end

  assign bus.rx_ready         = rx_ready_r;
  assign bus.tx_valid         = tx_valid_r;
  assign bus.tx_data          = tx_data_r;
  assign bus.cam_comparand    = comparand_r;
  assign bus.cam_mask         = mask_r;
  assign bus.cam_search       = search_r;
  assign bus.cam_select_first = select_r;
endmodule
